// File: rtl/dr_loader_pkg.sv
// Shared types and constants for the data-register byte loader.
// The optional WAIT timeout is enabled by defining DR_LOADER_TIMEOUT_EN.
package dr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] FS_SEXT = 2'b00;
  localparam logic [1:0] FS_ZEXT = 2'b01;
  localparam logic [1:0] FS_SHL  = 2'b10;
  localparam logic [1:0] FS_SHR  = 2'b11;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int TMO_W          = 4;

  // Highest byte index (N-1) for a legal size code.
  function automatic logic [1:0] last_index(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: last_index = 2'd0;
      SZ_HALF: last_index = 2'd1;
      default: last_index = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/dr_byte_loader.sv
// Fetches a 1/2/4-byte operand one byte at a time and shifts it MSB-first into the data register.
// Define DR_LOADER_TIMEOUT_EN to abort a WAIT that sees no mem_valid for TIMEOUT_CYCLES cycles.
module dr_byte_loader
  import dr_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic              little,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [7:0]        mem_data,
  output logic              dr_e,
  output logic [1:0]        dr_funsel,
  output logic [7:0]        dr_i,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_e            dbg_state
);

  // Handshake: mem_rd is a one-cycle request with mem_addr; the memory answers
  // later with a one-cycle mem_valid/mem_data, which is only accepted in WAIT.
  state_e            state_q;
  logic [1:0]        idx_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic              little_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              dr_e_q;
  logic [1:0]        dr_funsel_q;
  logic [7:0]        dr_i_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
`ifdef DR_LOADER_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q;
`endif

  logic [1:0]        first_off_d;
  logic [ADDR_W-1:0] first_addr_d;
  logic [1:0]        idx_d;
  logic [1:0]        next_off_d;
  logic [ADDR_W-1:0] next_addr_d;
  logic [1:0]        load_fs_d;

  // Little-endian operands are walked from the top byte down so the
  // register always receives the most significant byte first.
  always_comb begin
    first_off_d  = little ? last_index(size) : 2'd0;
    first_addr_d = base_addr + ADDR_W'(first_off_d);
    idx_d        = idx_q + 2'd1;
    next_off_d   = little_q ? (last_index(size_q) - idx_d) : idx_d;
    next_addr_d  = base_q + ADDR_W'(next_off_d);
    if (idx_q == 2'd0) begin
      load_fs_d = sext_q ? FS_SEXT : FS_ZEXT;
    end else begin
      load_fs_d = FS_SHL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      base_q      <= '0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      little_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      dr_e_q      <= 1'b0;
      dr_funsel_q <= 2'b00;
      dr_i_q      <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef DR_LOADER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      mem_rd_q <= 1'b0;
      dr_e_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (size == SZ_ILLEGAL) begin
              err_q <= 1'b1;
            end else begin
              base_q     <= base_addr;
              size_q     <= size;
              sext_q     <= sext;
              little_q   <= little;
              idx_q      <= 2'd0;
              state_q    <= ST_REQ;
              busy_q     <= 1'b1;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= first_addr_d;
            end
          end
        end
        ST_REQ: begin
          state_q    <= ST_WAIT;
          mem_addr_q <= '0;
`ifdef DR_LOADER_TIMEOUT_EN
          tmo_q      <= '0;
`endif
        end
        ST_WAIT: begin
          if (mem_valid) begin
            state_q     <= ST_LOAD;
            dr_e_q      <= 1'b1;
            dr_i_q      <= mem_data;
            dr_funsel_q <= load_fs_d;
          end
`ifdef DR_LOADER_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        ST_LOAD: begin
          dr_funsel_q <= 2'b00;
          dr_i_q      <= 8'h00;
          if (idx_q == last_index(size_q)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q      <= idx_d;
            state_q    <= ST_REQ;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= next_addr_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign dr_e      = dr_e_q;
  assign dr_funsel = dr_funsel_q;
  assign dr_i      = dr_i_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dr_byte_loader.sv
// Directed bench for dr_byte_loader with a 32-bit data-register model and a byte memory responder.
// Build with DR_LOADER_TIMEOUT_EN defined to exercise the WAIT timeout path.
module tb_dr_byte_loader;
  import dr_loader_pkg::*;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [1:0]        size = 2'b00;
  logic              sext = 1'b0;
  logic              little = 1'b0;
  logic              mem_valid = 1'b0;
  logic [7:0]        mem_data = 8'h00;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              dr_e;
  logic [1:0]        dr_funsel;
  logic [7:0]        dr_i;
  logic              busy;
  logic              done;
  logic              err;
  state_e            dbg_state;

  dr_byte_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .size(size), .sext(sext), .little(little), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .dr_e(dr_e), .dr_funsel(dr_funsel), .dr_i(dr_i), .busy(busy),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int k = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data register driven by the loader
  logic [31:0] dr_q = 32'h0;
  always @(posedge clk) begin
    if (dr_e) begin
      case (dr_funsel)
        2'b00:   dr_q <= {{24{dr_i[7]}}, dr_i};
        2'b01:   dr_q <= {24'h0, dr_i};
        2'b10:   dr_q <= {dr_q[23:0], dr_i};
        default: dr_q <= {dr_i, dr_q[31:8]};
      endcase
    end
  end

  // zero-wait memory: answers in the cycle after mem_rd while budget lasts
  logic [7:0]        mem_arr [int];
  int                resp_budget = 1000;
  logic              pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic              force_valid = 1'b0;
  logic [7:0]        force_data = 8'h00;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        mem_valid = 1'b1;
        mem_data  = mem_arr[int'(pend_addr)];
      end else if (force_valid) begin
        mem_valid = 1'b1;
        mem_data  = force_data;
      end else begin
        mem_valid = 1'b0;
        mem_data  = 8'h00;
      end
      pend = mem_rd && (resp_budget > 0);
      if (pend) begin
        pend_addr = mem_addr;
        resp_budget--;
      end
    end
  end

  // monitor
  logic [ADDR_W-1:0] addr_log[$];
  logic [1:0]        fs_log[$];
  int                load_cyc[$];
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, busy_cnt = 0, excl = 0;
  always @(negedge clk) begin
    if (mem_rd) addr_log.push_back(mem_addr);
    if (dr_e) begin
      fs_log.push_back(dr_funsel);
      load_cyc.push_back(cyc);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (busy) busy_cnt++;
    if ((int'(mem_rd) + int'(dr_e) + int'(done) + int'(err)) > 1) excl++;
  end

  // scoreboard
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    fs_log.delete();
    load_cyc.delete();
    done_cnt = 0; err_cnt = 0; busy_cnt = 0;
  endtask

  task automatic start_op(input logic [1:0] sz, input logic sx, input logic le,
                          input logic [ADDR_W-1:0] base);
    clear_logs();
    @(negedge clk);
    size = sz; sext = sx; little = le; base_addr = base; start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("end_within_budget", 32'(done_cnt + err_cnt != 0), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_addrs(input string tag);
    check({tag, "_nreads"}, 32'(addr_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++)
      check({tag, "_addr"}, 32'(addr_log[i]), exp_q[i]);
  endtask

  initial begin
    mem_arr[32'h0100] = 8'h12; mem_arr[32'h0101] = 8'h34;
    mem_arr[32'h0102] = 8'h56; mem_arr[32'h0103] = 8'h78;
    mem_arr[32'h0200] = 8'h80; mem_arr[32'h0201] = 8'hFF;
    mem_arr[32'h0300] = 8'hF0;
    mem_arr[32'hFFFE] = 8'hA1; mem_arr[32'hFFFF] = 8'hB2;
    mem_arr[32'h0000] = 8'hC3; mem_arr[32'h0001] = 8'hD4;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {mem_rd, dr_e, done, err, dr_funsel, dr_i, mem_addr}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // 4-byte big-endian, zero wait
    start_op(SZ_WORD, 1'b0, 1'b0, 16'h0100);
    wait_end(60);
    exp_q = '{32'h0100, 32'h0101, 32'h0102, 32'h0103};
    check_addrs("word_be");
    check("word_be_dr", dr_q, 32'h12345678);
    check("word_be_done_lat", 32'(done_cyc - k), 32'd13);
    check("word_be_ndone", 32'(done_cnt), 32'd1);
    check("word_be_load0_lat", 32'(load_cyc[0] - k), 32'd3);
    check("word_be_load3_lat", 32'(load_cyc[3] - k), 32'd12);
    check("word_be_fs", {fs_log[0], fs_log[1], fs_log[2], fs_log[3]}, 32'b01_10_10_10);
    check("word_be_idle", 32'(busy), 32'd0);

    // 2-byte little-endian, sign extend
    start_op(SZ_HALF, 1'b1, 1'b1, 16'h0200);
    wait_end(60);
    exp_q = '{32'h0201, 32'h0200};
    check_addrs("half_le");
    check("half_le_dr", dr_q, 32'hFFFFFF80);
    check("half_le_fs", {fs_log[0], fs_log[1]}, 32'b00_10);

    // single byte, zero and sign extend
    start_op(SZ_BYTE, 1'b0, 1'b0, 16'h0300);
    wait_end(60);
    check("byte_z_fs", 32'(fs_log[0]), 32'(FS_ZEXT));
    check("byte_z_dr", dr_q, 32'h000000F0);
    check("byte_z_done_lat", 32'(done_cyc - k), 32'd4);
    start_op(SZ_BYTE, 1'b1, 1'b0, 16'h0300);
    wait_end(60);
    check("byte_s_fs", 32'(fs_log[0]), 32'(FS_SEXT));
    check("byte_s_dr", dr_q, 32'hFFFFFFF0);

    // illegal size
    start_op(SZ_ILLEGAL, 1'b0, 1'b0, 16'h0100);
    repeat (6) @(negedge clk);
    check("illegal_err", 32'(err_cnt), 32'd1);
    check("illegal_err_lat", 32'(err_cyc - k), 32'd1);
    check("illegal_nreads", 32'(addr_log.size()), 32'd0);
    check("illegal_busy", 32'(busy_cnt), 32'd0);
    check("illegal_dr_kept", dr_q, 32'hFFFFFFF0);

    // start while busy is ignored
    start_op(SZ_WORD, 1'b0, 1'b0, 16'h0100);
    repeat (3) @(negedge clk);
    size = SZ_BYTE; little = 1'b1; sext = 1'b1; base_addr = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(60);
    exp_q = '{32'h0100, 32'h0101, 32'h0102, 32'h0103};
    check_addrs("busy_start");
    check("busy_start_dr", dr_q, 32'h12345678);
    repeat (3) @(negedge clk);
    check("busy_start_no_restart", 32'(busy), 32'd0);
    check("busy_start_nloads", 32'(fs_log.size()), 32'd4);

    // address wrap-around
    start_op(SZ_WORD, 1'b0, 1'b0, 16'hFFFE);
    wait_end(60);
    exp_q = '{32'hFFFE, 32'hFFFF, 32'h0000, 32'h0001};
    check_addrs("wrap");
    check("wrap_dr", dr_q, 32'hA1B2C3D4);

    // reset during WAIT of byte 2
    resp_budget = 1;
    start_op(SZ_WORD, 1'b0, 1'b0, 16'h0100);
    while (cyc < k + 5) @(negedge clk);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_WAIT));
    check("rst_mid_loads", 32'(fs_log.size()), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_no_more_loads", 32'(fs_log.size()), 32'd1);
    check("rst_mid_no_done_err", 32'(done_cnt + err_cnt), 32'd0);
    check("rst_mid_dr_kept", dr_q, 32'h00000012);

    // memory never answers
    resp_budget = 0;
`ifdef DR_LOADER_TIMEOUT_EN
    start_op(SZ_BYTE, 1'b0, 1'b0, 16'h0300);
    wait_end(40);
    check("tmo_err", 32'(err_cnt), 32'd1);
    check("tmo_err_lat", 32'(err_cyc - k), 32'd18);
    check("tmo_no_done", 32'(done_cnt), 32'd0);
    check("tmo_idle", 32'(busy), 32'd0);
`else
    start_op(SZ_BYTE, 1'b0, 1'b0, 16'h0300);
    repeat (40) @(negedge clk);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_state", 32'(dbg_state), 32'(ST_WAIT));
    check("hold_no_err", 32'(err_cnt), 32'd0);
    force_data = 8'h5A;
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    wait_end(20);
    check("hold_done", 32'(done_cnt), 32'd1);
    check("hold_dr", dr_q, 32'h0000005A);
`endif
    resp_budget = 1000;

    check("strobe_exclusive", 32'(excl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dr_byte_loader.md
DR_BYTE_LOADER -- requirements
Module: dr_byte_loader

Interface
REQ-001 Parameter ADDR_W, default 16, memory byte-address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 start  in  1  one-cycle load request; sampled only in IDLE.
REQ-005 base_addr  in  ADDR_W  lowest byte address of operand.
REQ-006 size  in  2  operand size: 00=1 byte, 01=2 bytes, 10=4 bytes, 11=illegal.
REQ-007 sext  in  1  1=sign-extend, 0=zero-extend the first loaded byte.
REQ-008 little  in  1  1=little-endian operand in memory, 0=big-endian.
REQ-009 mem_rd  out  1  one-cycle byte read strobe.
REQ-010 mem_addr  out  ADDR_W  byte address, valid while mem_rd=1.
REQ-011 mem_valid  in  1  memory response strobe; honoured only in WAIT.
REQ-012 mem_data  in  8  read byte, valid while mem_valid=1.
REQ-013 dr_e  out  1  data-register enable.
REQ-014 dr_funsel  out  2  data-register function: 00 sext, 01 zext, 10 shift-left+load, 11 shift-right+load.
REQ-015 dr_i  out  8  byte to data register.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse after last byte loaded.
REQ-018 err  out  1  one-cycle pulse on illegal size or timeout.

Function
REQ-019 States IDLE, REQ, WAIT, LOAD, DONE; all outputs driven from registers.
REQ-020 IDLE: start=1 with size!=11 latches base_addr/size/sext/little, clears index, enters REQ; size=11 pulses err next cycle, stays IDLE.
REQ-021 start while busy=1 ignored; latched operands unaffected.
REQ-022 Byte count N = 1, 2, 4; index i runs 0..N-1.
REQ-023 Fetch address: big-endian base+i, little-endian base+(N-1-i); ADDR_W wrap-around modulo 2^ADDR_W.
REQ-024 REQ: mem_rd=1 for exactly one cycle, then WAIT.
REQ-025 WAIT: mem_valid=1 captures mem_data, enters LOAD; mem_valid in any other state ignored.
REQ-026 LOAD: dr_e=1 one cycle, dr_i=captured byte; dr_funsel = (sext?00:01) for i=0, 10 for i>0; 11 never issued.
REQ-027 After LOAD: i=N-1 enters DONE, else i++ and REQ.
REQ-028 DONE: done=1 one cycle, return IDLE.
REQ-029 Zero-wait memory (mem_valid cycle after mem_rd): start at cycle k -> LOADs at k+3+3j, done at k+3N+1.
REQ-030 Resulting DROut: 1 byte = ext(b); 2 bytes = ext16 of MSB:LSB; 4 bytes = full word, MSB-first.
REQ-031 dr_e, mem_rd, done, err mutually exclusive in any cycle.

Reset
REQ-032 rst_n=0 at clock edge: state IDLE, index 0, all outputs 0, latched operands 0.
REQ-033 Reset mid-operation aborts immediately; no further dr_e, done, or err; data register content left as-is.

Configuration
REQ-034 With DR_LOADER_TIMEOUT_EN defined: WAIT counts cycles; 16 consecutive cycles without mem_valid pulse err, return IDLE, no done.
REQ-035 Without DR_LOADER_TIMEOUT_EN: WAIT holds indefinitely; no counter logic present; err only from illegal size.

Structure
REQ-036 Package dr_loader_pkg holds state enum, size codes, FunSel constants FS_SEXT/FS_ZEXT/FS_SHL/FS_SHR, TIMEOUT_CYCLES=16.
REQ-037 Single module; no sub-module; bench instantiates it with the data register.

Verification
REQ-038 size=10, little=0, base=0x0100, mem {0x12,0x34,0x56,0x78}, zero-wait -> reads 0x0100..0x0103, DROut=0x12345678, done at k+13.
REQ-039 size=01, little=1, sext=1, base=0x0200, mem[0x200]=0x80, mem[0x201]=0xFF -> reads 0x201 then 0x200, DROut=0xFFFFFF80.
REQ-040 size=00, sext=0, byte 0xF0 -> funsel 01, DROut=0x000000F0; sext=1 -> funsel 00, DROut=0xFFFFFFF0.
REQ-041 size=11 -> err one pulse, no mem_rd, busy stays 0; start pulse during busy -> ignored, operation unchanged.
REQ-042 base=0xFFFE, size=10, big-endian -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-043 rst_n=0 during WAIT of byte 2 -> next cycle busy=0, no dr_e/done; with DR_LOADER_TIMEOUT_EN, mem_valid withheld 16 cycles -> err pulse, no done.
